// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared definitions for the BCD mm:ss countdown timer.
//   - state_t           : controller states
//   - *_MAX             : wrap value of each BCD digit stage
//   - *_LSB             : bit offset of each digit inside the packed 16-bit value
//   - clamp_digit       : clamps one BCD digit to a stage maximum
//   - sanitise_preset   : clamps every digit of a packed preset to its stage maximum
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;

  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  function automatic logic [15:0] sanitise_preset(input logic [15:0] p);
    logic [15:0] r;
    r = 16'h0000;
    r[SEC_ONES_LSB +: 4] = clamp_digit(p[SEC_ONES_LSB +: 4], SEC_ONES_MAX);
    r[SEC_TENS_LSB +: 4] = clamp_digit(p[SEC_TENS_LSB +: 4], SEC_TENS_MAX);
    r[MIN_ONES_LSB +: 4] = clamp_digit(p[MIN_ONES_LSB +: 4], MIN_ONES_MAX);
    r[MIN_TENS_LSB +: 4] = clamp_digit(p[MIN_TENS_LSB +: 4], MIN_TENS_MAX);
    return r;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit
// One stage of the BCD down-counting borrow chain. Decrements when dec_in is
// high; a stage at zero wraps to MAX and raises borrow_out for the next stage.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : synchronous load of load_val (takes priority over dec_in)
//   load_val     : value to load (already sanitised by the caller)
//   dec_in       : decrement request for this stage
//   digit        : registered digit value
//   borrow_out   : decrement request for the next stage up
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  // Digit register: load, wrap-on-borrow decrement, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec_in) begin
      digit <= (digit == 4'd0) ? MAX : (digit - 4'd1);
    end else begin
      digit <= digit;
    end
  end

  assign borrow_out = (digit == 4'd0) & dec_in;

endmodule

// File: rtl/countdown_mmss.sv
// countdown_mmss
// BCD minutes:seconds countdown timer. Counts down once every TICK_DIV clocks
// from a loaded preset and flags expiry when 00:00 is reached.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load preset (ignored while running)
//   preset     : BCD {min_tens, min_ones, sec_tens, sec_ones}
//   start      : begin / resume counting
//   pause      : hold counting (wins over start)
//   digits     : current BCD value, same packing as preset
//   running    : high while counting
//   expired    : high from reaching 00:00 until the next load
//   done       : one-cycle pulse on reaching 00:00
module countdown_mmss
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_r;
  logic [PW-1:0] prescaler_r;

  logic [15:0] preset_clean_s;
  logic        load_en_s;
  logic        tick_s;
  logic        terminal_s;

  logic [3:0] sec_ones_r, sec_tens_r, min_ones_r, min_tens_r;
  logic       sec_ones_borrow_s, sec_tens_borrow_s, min_ones_borrow_s, min_tens_borrow_s;

  assign preset_clean_s = sanitise_preset(preset);

  // load is honoured everywhere except RUN.
  assign load_en_s  = load & (state_r != ST_RUN);
  // A paused cycle never counts, so a pause arriving on the last prescaler
  // count defers the decrement rather than losing it.
  assign tick_s     = (state_r == ST_RUN) & ~pause & (prescaler_r == PRESC_LAST);
  assign terminal_s = tick_s & (digits == 16'h0001);

  bcd_down_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .load(load_en_s),
    .load_val(preset_clean_s[SEC_ONES_LSB +: 4]), .dec_in(tick_s),
    .digit(sec_ones_r), .borrow_out(sec_ones_borrow_s)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .load(load_en_s),
    .load_val(preset_clean_s[SEC_TENS_LSB +: 4]), .dec_in(sec_ones_borrow_s),
    .digit(sec_tens_r), .borrow_out(sec_tens_borrow_s)
  );

  bcd_down_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .load(load_en_s),
    .load_val(preset_clean_s[MIN_ONES_LSB +: 4]), .dec_in(sec_tens_borrow_s),
    .digit(min_ones_r), .borrow_out(min_ones_borrow_s)
  );

  // The top stage's borrow would mean wrapping past 00:00, which the
  // terminal detect prevents, so it is left unconnected downstream.
  bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .load(load_en_s),
    .load_val(preset_clean_s[MIN_TENS_LSB +: 4]), .dec_in(min_ones_borrow_s),
    .digit(min_tens_r), .borrow_out(min_tens_borrow_s)
  );

  assign digits = {min_tens_r, min_ones_r, sec_tens_r, sec_ones_r};

  // Controller FSM with prescaler and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      prescaler_r <= '0;
      running     <= 1'b0;
      expired     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            prescaler_r <= '0;
          end else if (pause) begin
            state_r <= ST_IDLE;
          end else if (start && (digits != 16'h0000)) begin
            state_r     <= ST_RUN;
            prescaler_r <= '0;
            running     <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_r <= ST_PAUSE;
            running <= 1'b0;
          end else if (terminal_s) begin
            state_r     <= ST_DONE;
            prescaler_r <= '0;
            running     <= 1'b0;
            expired     <= 1'b1;
            done        <= 1'b1;
          end else if (tick_s) begin
            prescaler_r <= '0;
          end else begin
            prescaler_r <= prescaler_r + {{(PW-1){1'b0}}, 1'b1};
          end
        end
        ST_PAUSE: begin
          if (load) begin
            state_r     <= ST_IDLE;
            prescaler_r <= '0;
          end else if (pause) begin
            state_r <= ST_PAUSE;
          end else if (start) begin
            state_r <= ST_RUN;
            running <= 1'b1;
          end else begin
            state_r <= ST_PAUSE;
          end
        end
        ST_DONE: begin
          if (load) begin
            state_r     <= ST_IDLE;
            prescaler_r <= '0;
            expired     <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          prescaler_r <= '0;
          running     <= 1'b0;
          expired     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_mmss.sv
// tb_countdown_mmss
// Randomised and directed bench for countdown_mmss (TICK_DIV = 4). A reference
// model tracks the remaining time in plain seconds and the number of counting
// cycles spent in the current second; expected digits are derived from it.
module tb_countdown_mmss;

  localparam int TICK_DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int m_state = M_IDLE;
  int m_secs  = 0;
  int m_phase = 0;
  bit m_done  = 1'b0;

  countdown_mmss #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .preset(preset),
    .start(start), .pause(pause), .digits(digits),
    .running(running), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Preset to seconds, with each digit clamped to its legal range.
  function automatic int preset_secs(input logic [15:0] p);
    int mt, mo, st, so;
    mt = min_i(int'(p[15:12]), 5);
    mo = min_i(int'(p[11:8]), 9);
    st = min_i(int'(p[7:4]), 5);
    so = min_i(int'(p[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] secs_bcd(input int s);
    int m, ss;
    logic [15:0] r;
    m  = s / 60;
    ss = s % 60;
    r = {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    return r;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_secs = 0; m_phase = 0; m_done = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs at that edge.
  task automatic model_step();
    m_done = 1'b0;
    case (m_state)
      M_IDLE: begin
        if (load) begin m_secs = preset_secs(preset); m_phase = 0; end
        else if (!pause && start && m_secs != 0) begin m_state = M_RUN; m_phase = 0; end
      end
      M_RUN: begin
        if (pause) m_state = M_PAUSE;
        else begin
          m_phase++;
          if (m_phase == TICK_DIV) begin
            m_phase = 0;
            m_secs--;
            if (m_secs == 0) begin m_state = M_DONE; m_done = 1'b1; end
          end
        end
      end
      M_PAUSE: begin
        if (load) begin m_state = M_IDLE; m_secs = preset_secs(preset); m_phase = 0; end
        else if (!pause && start) m_state = M_RUN;
      end
      default: begin
        if (load) begin m_state = M_IDLE; m_secs = preset_secs(preset); m_phase = 0; end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".digits"},  32'(digits),  32'(secs_bcd(m_secs)));
    check_eq({tag, ".running"}, 32'(running), 32'(m_state == M_RUN));
    check_eq({tag, ".expired"}, 32'(expired), 32'(m_state == M_DONE));
    check_eq({tag, ".done"},    32'(done),    32'(m_done));
  endtask

  // Drive inputs at negedge, advance the model at posedge, compare just after.
  task automatic cycle(input bit l, input logic [15:0] p, input bit s, input bit pa);
    @(negedge clk);
    load = l; preset = p; start = s; pause = pa;
    @(posedge clk);
    model_step();
    #1;
    check_model("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.digits",  32'(digits),  32'h0000);
    check_eq("reset.running", 32'(running), 32'h0);
    check_eq("reset.expired", 32'(expired), 32'h0);
    check_eq("reset.done",    32'(done),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 00:12 counting down through a sec_tens borrow
    cycle(1'b1, 16'h0012, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("start.running", 32'(running), 32'h1);
    for (int n = 1; n <= 12; n++) begin
      cycle(1'b0, 16'h0000, 1'b0, 1'b0);
      if (n == 4)  check_eq("d0012+4",  32'(digits), 32'h0011);
      if (n == 8)  check_eq("d0012+8",  32'(digits), 32'h0010);
      if (n == 12) check_eq("d0012+12", 32'(digits), 32'h0009);
    end

    // 10:00 -> 09:59 and 01:00 -> 00:59
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b1, 16'h1000, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(4);
    check_eq("d1000_tick", 32'(digits), 32'h0959);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b1, 16'h0100, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(4);
    check_eq("d0100_tick", 32'(digits), 32'h0059);

    // expiry from 00:02
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b1, 16'h0002, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(4);
    check_eq("d0002+4", 32'(digits), 32'h0001);
    idle(4);
    check_eq("d0002+8", 32'(digits), 32'h0000);
    check_eq("done_pulse", 32'(done), 32'h1);
    check_eq("expired_set", 32'(expired), 32'h1);
    idle(1);
    check_eq("done_clear", 32'(done), 32'h0);
    check_eq("expired_hold", 32'(expired), 32'h1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("done_start_ign", 32'(running), 32'h0);
    cycle(1'b1, 16'h0030, 1'b0, 1'b0);
    check_eq("reload.expired", 32'(expired), 32'h0);
    check_eq("reload.digits",  32'(digits),  32'h0030);

    // pause for 10 cycles delays the first decrement to +14
    cycle(1'b1, 16'h0005, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);       // edge k
    idle(1);                                  // k+1
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);       // k+2
    idle(8);                                  // k+3..k+10
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);       // k+11
    idle(2);                                  // k+12, k+13
    check_eq("pause.k13", 32'(digits), 32'h0005);
    idle(1);                                  // k+14
    check_eq("pause.k14", 32'(digits), 32'h0004);

    // sanitised preset, start+pause from IDLE, start at zero
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b1, 16'h7A9F, 1'b0, 1'b0);
    check_eq("sanitise", 32'(digits), 32'h5959);
    cycle(1'b0, 16'h0000, 1'b1, 1'b1);
    check_eq("start_pause_idle", 32'(running), 32'h0);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("zero_start.running", 32'(running), 32'h0);
    idle(6);
    check_eq("zero_start.done", 32'(done), 32'h0);

    // asynchronous reset mid-run
    cycle(1'b1, 16'h0100, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    idle(6);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst.digits",  32'(digits),  32'h0000);
    check_eq("arst.running", 32'(running), 32'h0);
    check_eq("arst.done",    32'(done),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit l, s, pa;
      logic [15:0] p;
      l  = ($urandom_range(0, 99) < 5);
      s  = ($urandom_range(0, 99) < 12);
      pa = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) p = 16'($urandom);
      else p = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      cycle(l, p, s, pa);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
